// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer round controller: FSM state
// encoding and packed-BCD constants.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GO    = 3'd2,
    ST_SHOW  = 3'd3,
    ST_FAULT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  // Packed BCD orders the same as plain binary, so a straight unsigned
  // compare ranks two reaction times correctly.
  function automatic logic bcd_less(input logic [15:0] a, input logic [15:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the round controller (master) and its environment:
// buttons, tick, random source, BCD counter link and display/lamp outputs.
interface reaction_round_ctrl_if #(
  parameter int DELAY_W = 12
);
  logic               tick_1k;
  logic               start_btn;
  logic               react_btn;
  logic [DELAY_W-1:0] rnd_delay;
  logic [15:0]        time_bcd;
  logic               bcd_clr;
  logic               bcd_en;
  logic               led;
  logic               fault_led;
  logic [1:0]         round_idx;
  logic [15:0]        disp_bcd;
  logic               best_valid;
  logic               done;

  modport master (
    input  tick_1k, start_btn, react_btn, rnd_delay, time_bcd,
    output bcd_clr, bcd_en, led, fault_led, round_idx, disp_bcd, best_valid, done
  );

  modport slave (
    output tick_1k, start_btn, react_btn, rnd_delay, time_bcd,
    input  bcd_clr, bcd_en, led, fault_led, round_idx, disp_bcd, best_valid, done
  );
endinterface

// File: rtl/ms_down_counter.sv
// Millisecond down-counter: loadable, decrements once per enabled tick and
// parks at zero.
module ms_down_counter #(
  parameter int W = 12
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer session controller: random arm delay, timed go phase,
// result/fault hold, best-of-session tracking over ROUNDS rounds.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int ROUNDS    = 3,
  parameter int DELAY_W   = 12,
  parameter int MIN_DELAY = 500,
  parameter int SHOW_MS   = 2000
) (
  input logic Clk,
  input logic Reset,
  reaction_round_ctrl_if.master io
);

  localparam int CNT_W  = DELAY_W + 1;
  localparam int HOLD_W = (SHOW_MS < 2) ? 1 : $clog2(SHOW_MS + 1);

  state_t             state;
  logic [15:0]        best_bcd;
  logic [15:0]        last_bcd;
  logic [CNT_W-1:0]   dly_val;
  logic               dly_zero;
  logic [HOLD_W-1:0]  hold_val;
  logic               hold_zero;
  logic               dly_expire;
  logic               hold_expire;
  logic               hold_end;
  logic               last_round;
  logic               arm_load;
  logic               hold_load;

  // A window closes on the tick that takes the counter from 1 to 0; a counter
  // already at zero closes on the first tick so a window can never stall.
  always_comb begin
    dly_expire  = io.tick_1k && ((dly_val == CNT_W'(1)) || dly_zero);
    hold_expire = io.tick_1k && ((hold_val == HOLD_W'(1)) || hold_zero);
    hold_end    = hold_expire || io.start_btn;
    last_round  = (io.round_idx == 2'(ROUNDS - 1));
    arm_load    = 1'b0;
    hold_load   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: arm_load  = io.start_btn;
      ST_ARM:           hold_load = io.react_btn;
      ST_GO:            hold_load = io.react_btn || (io.time_bcd == BCD_MAX);
      ST_SHOW:          arm_load  = hold_end && !last_round;
      ST_FAULT:         arm_load  = hold_end;
      default:          ;
    endcase
  end

  ms_down_counter #(.W(CNT_W)) u_delay (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (arm_load),
    .load_val (CNT_W'(MIN_DELAY) + {1'b0, io.rnd_delay}),
    .tick     (io.tick_1k && (state == ST_ARM)),
    .value    (dly_val),
    .zero     (dly_zero)
  );

  ms_down_counter #(.W(HOLD_W)) u_hold (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (hold_load),
    .load_val (HOLD_W'(SHOW_MS)),
    .tick     (io.tick_1k && ((state == ST_SHOW) || (state == ST_FAULT))),
    .value    (hold_val),
    .zero     (hold_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      io.led        <= 1'b0;
      io.fault_led  <= 1'b0;
      io.bcd_en     <= 1'b0;
      io.bcd_clr    <= 1'b0;
      io.done       <= 1'b0;
      io.best_valid <= 1'b0;
      io.round_idx  <= 2'd0;
      io.disp_bcd   <= BCD_ZERO;
      best_bcd      <= BCD_MAX;
      last_bcd      <= BCD_MAX;
    end else begin
      io.bcd_clr <= arm_load;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (io.start_btn) begin
            state         <= ST_ARM;
            io.done       <= 1'b0;
            io.round_idx  <= 2'd0;
            io.disp_bcd   <= BCD_ZERO;
            io.best_valid <= 1'b0;
            best_bcd      <= BCD_MAX;
          end
        end
        ST_ARM: begin
          if (io.react_btn) begin
            state        <= ST_FAULT;
            io.fault_led <= 1'b1;
            io.disp_bcd  <= BCD_ZERO;
          end else if (dly_expire) begin
            state     <= ST_GO;
            io.led    <= 1'b1;
            io.bcd_en <= 1'b1;
          end
        end
        ST_GO: begin
          io.disp_bcd <= io.time_bcd;
          // A counter that saturates at 9999 without a press is a miss:
          // shown like a result but never considered for best.
          if (io.react_btn || (io.time_bcd == BCD_MAX)) begin
            state     <= ST_SHOW;
            io.led    <= 1'b0;
            io.bcd_en <= 1'b0;
            last_bcd  <= io.time_bcd;
            if (io.react_btn && bcd_less(io.time_bcd, best_bcd)) begin
              best_bcd      <= io.time_bcd;
              io.best_valid <= 1'b1;
            end
          end
        end
        ST_SHOW: begin
          io.disp_bcd <= last_bcd;
          if (hold_end) begin
            if (last_round) begin
              state       <= ST_DONE;
              io.done     <= 1'b1;
              io.disp_bcd <= best_bcd;
            end else begin
              state        <= ST_ARM;
              io.round_idx <= io.round_idx + 2'd1;
              io.disp_bcd  <= BCD_ZERO;
            end
          end
        end
        ST_FAULT: begin
          if (hold_end) begin
            state        <= ST_ARM;
            io.fault_led <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: directed session scenarios, a behavioural
// session model compared every cycle, and hand-computed spot checks.
module tb_reaction_round_ctrl;

  localparam int ROUNDS    = 3;
  localparam int DELAY_W   = 12;
  localparam int MIN_DELAY = 500;
  localparam int SHOW_MS   = 2000;

  logic Clk;
  logic Reset;

  reaction_round_ctrl_if #(.DELAY_W(DELAY_W)) bus ();

  reaction_round_ctrl #(
    .ROUNDS    (ROUNDS),
    .DELAY_W   (DELAY_W),
    .MIN_DELAY (MIN_DELAY),
    .SHOW_MS   (SHOW_MS)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int tdiv  = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural session model ----------------
  typedef enum int {M_READY, M_WAITING, M_TIMING, M_RESULT, M_PENALTY, M_FINISHED} mode_t;
  mode_t       mode;
  int          m_cnt;
  int          m_target;
  logic [15:0] results[$];
  logic        e_led, e_fault, e_en, e_clr, e_done;
  logic [1:0]  e_idx;
  logic [15:0] e_disp;

  function automatic logic [15:0] m_best();
    logic [15:0] b = 16'h9999;
    foreach (results[i]) if (results[i] < b) b = results[i];
    return b;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      mode    <= M_READY;
      m_cnt   <= 0;
      e_led   <= 1'b0;
      e_fault <= 1'b0;
      e_en    <= 1'b0;
      e_clr   <= 1'b0;
      e_done  <= 1'b0;
      e_idx   <= 2'd0;
      e_disp  <= 16'h0000;
      results.delete();
    end else begin
      e_clr <= 1'b0;
      case (mode)
        M_READY, M_FINISHED: if (bus.start_btn) begin
          mode     <= M_WAITING;
          m_cnt    <= 0;
          m_target <= MIN_DELAY + int'(bus.rnd_delay);
          e_clr    <= 1'b1;
          e_idx    <= 2'd0;
          e_done   <= 1'b0;
          e_disp   <= 16'h0000;
          results.delete();
        end
        M_WAITING: begin
          if (bus.react_btn) begin
            mode    <= M_PENALTY;
            m_cnt   <= 0;
            e_fault <= 1'b1;
          end else if (bus.tick_1k) begin
            if (m_cnt + 1 == m_target) begin
              mode  <= M_TIMING;
              e_led <= 1'b1;
              e_en  <= 1'b1;
            end else m_cnt <= m_cnt + 1;
          end
        end
        M_TIMING: begin
          e_disp <= bus.time_bcd;
          if (bus.react_btn || bus.time_bcd == 16'h9999) begin
            if (bus.react_btn) results.push_back(bus.time_bcd);
            mode  <= M_RESULT;
            m_cnt <= 0;
            e_led <= 1'b0;
            e_en  <= 1'b0;
          end
        end
        M_RESULT: begin
          if (bus.start_btn || (bus.tick_1k && m_cnt + 1 == SHOW_MS)) begin
            if (int'(e_idx) == ROUNDS - 1) begin
              mode   <= M_FINISHED;
              e_done <= 1'b1;
              e_disp <= m_best();
            end else begin
              mode     <= M_WAITING;
              m_cnt    <= 0;
              m_target <= MIN_DELAY + int'(bus.rnd_delay);
              e_clr    <= 1'b1;
              e_idx    <= e_idx + 2'd1;
              e_disp   <= 16'h0000;
            end
          end else if (bus.tick_1k) m_cnt <= m_cnt + 1;
        end
        M_PENALTY: begin
          if (bus.start_btn || (bus.tick_1k && m_cnt + 1 == SHOW_MS)) begin
            mode     <= M_WAITING;
            m_cnt    <= 0;
            m_target <= MIN_DELAY + int'(bus.rnd_delay);
            e_clr    <= 1'b1;
            e_fault  <= 1'b0;
          end else if (bus.tick_1k) m_cnt <= m_cnt + 1;
        end
        default: mode <= M_READY;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("led",        16'(bus.led),        16'(e_led));
      chk("fault_led",  16'(bus.fault_led),  16'(e_fault));
      chk("bcd_en",     16'(bus.bcd_en),     16'(e_en));
      chk("bcd_clr",    16'(bus.bcd_clr),    16'(e_clr));
      chk("done",       16'(bus.done),       16'(e_done));
      chk("round_idx",  16'(bus.round_idx),  16'(e_idx));
      chk("disp_bcd",   bus.disp_bcd,        e_disp);
      chk("best_valid", 16'(bus.best_valid), 16'(m_best() != 16'h9999));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_step();
    @(posedge Clk);
    #1;
    bus.start_btn = 1'b0;
    bus.react_btn = 1'b0;
    bus.tick_1k   = (tdiv == 3);
    tdiv          = (tdiv + 1) % 4;
  endtask

  // Returns just after the edge that samples the n-th tick.
  task automatic run_ticks(input int n);
    int nt = 0;
    int g  = 0;
    while (nt < n && g < 8 * n + 16) begin
      if (bus.tick_1k) nt++;
      cyc_step();
      g++;
    end
  endtask

  task automatic wait_led();
    int g = 0;
    while (bus.led !== 1'b1 && g < 30000) begin
      cyc_step();
      g++;
    end
    chk("go_reached", 16'(bus.led), 16'd1);
  endtask

  task automatic react_at(input logic [15:0] t);
    wait_led();
    bus.time_bcd  = t;
    bus.react_btn = 1'b1;
    cyc_step();
    bus.time_bcd = 16'h0000;
  endtask

  initial begin
    int g;
    Reset         = 1'b1;
    bus.tick_1k   = 1'b0;
    bus.start_btn = 1'b0;
    bus.react_btn = 1'b0;
    bus.rnd_delay = '0;
    bus.time_bcd  = 16'h0000;
    cyc_step();
    chk_on = 1'b1;
    cyc_step();
    chk("rst_led",  16'(bus.led),        16'd0);
    chk("rst_disp", bus.disp_bcd,        16'h0000);
    chk("rst_idx",  16'(bus.round_idx),  16'd0);
    chk("rst_bv",   16'(bus.best_valid), 16'd0);
    chk("rst_done", 16'(bus.done),       16'd0);
    Reset = 1'b0;

    // react is ignored while idle
    cyc_step();
    bus.react_btn = 1'b1;
    cyc_step();
    chk("idle_react_fault", 16'(bus.fault_led), 16'd0);

    // zero random delay: go lamp after exactly 500 ticks
    bus.rnd_delay = '0;
    bus.start_btn = 1'b1;
    cyc_step();
    chk("arm_clr", 16'(bus.bcd_clr), 16'd1);
    run_ticks(499);
    chk("led_before_500", 16'(bus.led), 16'd0);
    run_ticks(1);
    chk("led_at_500", 16'(bus.led), 16'd1);
    chk("en_at_500", 16'(bus.bcd_en), 16'd1);

    // display follows time one cycle late, then react at 0234
    bus.time_bcd = 16'h0100;
    cyc_step();
    chk("disp_follow", bus.disp_bcd, 16'h0100);
    bus.time_bcd  = 16'h0234;
    bus.react_btn = 1'b1;
    cyc_step();
    bus.time_bcd = 16'h0000;
    chk("react_disp", bus.disp_bcd, 16'h0234);
    chk("react_bv", 16'(bus.best_valid), 16'd1);
    chk("react_led", 16'(bus.led), 16'd0);

    // skip result hold, then abandon round 1 with reset during go
    bus.rnd_delay = 12'd3;
    bus.start_btn = 1'b1;
    cyc_step();
    chk("r1_idx", 16'(bus.round_idx), 16'd1);
    wait_led();
    bus.time_bcd = 16'h0050;
    cyc_step();
    cyc_step();
    Reset         = 1'b1;
    bus.start_btn = 1'b1;
    bus.react_btn = 1'b1;
    cyc_step();
    Reset = 1'b0;
    bus.time_bcd = 16'h0000;
    chk("midgo_rst_led", 16'(bus.led), 16'd0);
    chk("midgo_rst_idx", 16'(bus.round_idx), 16'd0);
    chk("midgo_rst_bv", 16'(bus.best_valid), 16'd0);
    chk("midgo_rst_clr", 16'(bus.bcd_clr), 16'd0);
    cyc_step();
    bus.rnd_delay = 12'd10;
    bus.start_btn = 1'b1;
    cyc_step();
    chk("restart_clr", 16'(bus.bcd_clr), 16'd1);
    chk("restart_idx", 16'(bus.round_idx), 16'd0);

    // false start coinciding with a tick
    g = 0;
    while (!bus.tick_1k && g < 8) begin
      cyc_step();
      g++;
    end
    bus.react_btn = 1'b1;
    cyc_step();
    chk("fault_on", 16'(bus.fault_led), 16'd1);
    chk("fault_led_go", 16'(bus.led), 16'd0);
    run_ticks(SHOW_MS - 1);
    chk("fault_held", 16'(bus.fault_led), 16'd1);
    run_ticks(1);
    chk("fault_off", 16'(bus.fault_led), 16'd0);
    chk("fault_rearm_clr", 16'(bus.bcd_clr), 16'd1);
    chk("fault_idx", 16'(bus.round_idx), 16'd0);

    // three scored rounds: 0412, 0287, 0287
    react_at(16'h0412);
    chk("r0_disp", bus.disp_bcd, 16'h0412);
    bus.react_btn = 1'b1;
    cyc_step();
    chk("show_react_ignored", bus.disp_bcd, 16'h0412);
    bus.start_btn = 1'b1;
    cyc_step();
    react_at(16'h0287);
    chk("r1b_disp", bus.disp_bcd, 16'h0287);
    run_ticks(SHOW_MS - 1);
    chk("show_held_idx", 16'(bus.round_idx), 16'd1);
    run_ticks(1);
    chk("show_expired_idx", 16'(bus.round_idx), 16'd2);
    chk("show_expired_disp", bus.disp_bcd, 16'h0000);
    wait_led();
    bus.start_btn = 1'b1;
    cyc_step();
    chk("go_start_ignored", 16'(bus.led), 16'd1);
    bus.time_bcd  = 16'h0287;
    bus.react_btn = 1'b1;
    cyc_step();
    bus.time_bcd  = 16'h0000;
    bus.start_btn = 1'b1;
    cyc_step();
    chk("done_flag", 16'(bus.done), 16'd1);
    chk("done_disp", bus.disp_bcd, 16'h0287);
    chk("done_idx", 16'(bus.round_idx), 16'd2);

    // new session, first round is a miss
    bus.start_btn = 1'b1;
    cyc_step();
    chk("sess_done_clr", 16'(bus.done), 16'd0);
    chk("sess_bv_clr", 16'(bus.best_valid), 16'd0);
    wait_led();
    bus.time_bcd = 16'h9999;
    cyc_step();
    bus.time_bcd = 16'h0000;
    chk("miss_disp", bus.disp_bcd, 16'h9999);
    chk("miss_bv", 16'(bus.best_valid), 16'd0);
    chk("miss_led", 16'(bus.led), 16'd0);
    cyc_step();
    cyc_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
